ak4619_tdm_responder: RTL

AK4619_TDM_RESPONDER -- requirements
Module: ak4619_tdm_responder

---
 rtl/ak4619_tdm_responder_if.sv | 39 +++
 rtl/ak4619_tdm_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ak4619_tdm_responder_if.sv
`default_nettype none
// ==========================================================================
// ak4619_tdm_responder_if -- TDM serial pins and parallel sample bus. Rev 1.0
// ==========================================================================
interface ak4619_tdm_responder_if #(
  parameter int W = 16
);
  logic                pdn;
  logic                bick;
  logic                lrck;
  logic                sdin1;
  logic                sdout1;
  logic signed [W-1:0] sample_in0;
  logic signed [W-1:0] sample_in1;
  logic signed [W-1:0] sample_in2;
  logic signed [W-1:0] sample_in3;
  logic signed [W-1:0] sample_out0;
  logic signed [W-1:0] sample_out1;
  logic signed [W-1:0] sample_out2;
  logic signed [W-1:0] sample_out3;
  logic                sample_valid;
  logic                locked;
  logic                frame_err;

  modport master (
    output pdn, bick, lrck, sdin1,
    output sample_in0, sample_in1, sample_in2, sample_in3,
    input  sdout1, sample_out0, sample_out1, sample_out2, sample_out3,
    input  sample_valid, locked, frame_err
  );

  modport slave (
    input  pdn, bick, lrck, sdin1,
    input  sample_in0, sample_in1, sample_in2, sample_in3,
    output sdout1, sample_out0, sample_out1, sample_out2, sample_out3,
    output sample_valid, locked, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/ak4619_tdm_responder.sv
`default_nettype none
// ==========================================================================
// ak4619_tdm_responder -- AK4619 TDM128 slave: 4x32-bit slots in/out. Rev 1.0
// ==========================================================================
module ak4619_tdm_responder #(
  parameter int W = 16
) (
  input  logic                  clk_256fs,
  input  logic                  rst_n,
  ak4619_tdm_responder_if.slave bus
);
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [5:0] C_W    = 6'(W);
  localparam logic [6:0] C_LAST = 7'd127;

  state_t       state_q, state_d;
  logic         bick_s1_q, bick_s2_q, bick_s3_q;
  logic         lrck_s1_q, lrck_s2_q;
  logic         sdin_s1_q, sdin_s2_q;
  logic         lrck_prev_q, lrck_prev_d;
  logic [6:0]   bit_idx_q, bit_idx_d;
  logic [W-1:0] rx_q [4];
  logic [W-1:0] rx_d [4];
  logic [W-1:0] tx_q [4];
  logic [W-1:0] tx_d [4];
  logic [W-1:0] out_q [4];
  logic [W-1:0] out_d [4];
  logic         sdout_q, sdout_d;
  logic         valid_q, valid_d;
  logic         locked_q, locked_d;
  logic         err_q, err_d;

  logic         bick_rise, bick_fall, frame_start, capture;
  logic [6:0]   nxt_idx;
  logic [31:0]  tx_word;

  assign bick_rise   = bick_s2_q & ~bick_s3_q;
  assign bick_fall   = ~bick_s2_q & bick_s3_q;
  assign frame_start = bick_rise & lrck_s2_q & ~lrck_prev_q;
  assign nxt_idx     = bit_idx_q + 7'd1;
  // Sample left-justified in a 32-bit slot, so padding positions read as 0.
  assign tx_word     = 32'(tx_q[nxt_idx[6:5]]) << (32 - W);

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    lrck_prev_d = bick_rise ? lrck_s2_q : lrck_prev_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    out_d       = out_q;
    sdout_d     = sdout_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    locked_d    = locked_q;
    capture     = 1'b0;

    if (!bus.pdn) begin
      state_d   = ST_IDLE;
      bit_idx_d = '0;
      locked_d  = 1'b0;
      sdout_d   = 1'b0;
      for (int i = 0; i < 4; i++) tx_d[i] = '0;
    end else if (bick_rise) begin
      if (state_q == ST_IDLE) begin
        if (frame_start) begin
          state_d   = ST_RUN;
          bit_idx_d = '0;
          capture   = 1'b1;
        end
      end else if (frame_start) begin
        bit_idx_d = '0;
        capture   = 1'b1;
        if (bit_idx_q == C_LAST) begin
          locked_d = 1'b1;
        end else begin
          err_d    = 1'b1;
          locked_d = 1'b0;
        end
      end else if (bit_idx_q == C_LAST) begin
        err_d     = 1'b1;
        locked_d  = 1'b0;
        state_d   = ST_IDLE;
        bit_idx_d = '0;
        sdout_d   = 1'b0;
      end else begin
        bit_idx_d = nxt_idx;
        capture   = 1'b1;
      end

      if (capture && ({1'b0, bit_idx_d[4:0]} < C_W)) begin
        rx_d[bit_idx_d[6:5]] = {rx_q[bit_idx_d[6:5]][W-2:0], sdin_s2_q};
      end
      if (capture && (bit_idx_d == C_LAST)) begin
        out_d   = rx_d;
        valid_d = 1'b1;
        tx_d[0] = bus.sample_in0;
        tx_d[1] = bus.sample_in1;
        tx_d[2] = bus.sample_in2;
        tx_d[3] = bus.sample_in3;
      end
    end else if (bick_fall) begin
      sdout_d = (state_q == ST_RUN) ? tx_word[5'd31 - nxt_idx[4:0]] : 1'b0;
    end
  end

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bick_s1_q   <= 1'b0;
      bick_s2_q   <= 1'b0;
      bick_s3_q   <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      sdin_s1_q   <= 1'b0;
      sdin_s2_q   <= 1'b0;
      // Start as "high" so an lrck already high at reset release is not a frame start.
      lrck_prev_q <= 1'b1;
      bit_idx_q   <= '0;
      sdout_q     <= 1'b0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rx_q[i]  <= '0;
        tx_q[i]  <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bick_s1_q   <= bus.bick;
      bick_s2_q   <= bick_s1_q;
      bick_s3_q   <= bick_s2_q;
      lrck_s1_q   <= bus.lrck;
      lrck_s2_q   <= lrck_s1_q;
      sdin_s1_q   <= bus.sdin1;
      sdin_s2_q   <= sdin_s1_q;
      lrck_prev_q <= lrck_prev_d;
      bit_idx_q   <= bit_idx_d;
      sdout_q     <= sdout_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      out_q       <= out_d;
    end
  end

  assign bus.sdout1       = sdout_q;
  assign bus.sample_out0  = out_q[0];
  assign bus.sample_out1  = out_q[1];
  assign bus.sample_out2  = out_q[2];
  assign bus.sample_out3  = out_q[3];
  assign bus.sample_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.frame_err    = err_q;
endmodule
`default_nettype wire
